// File: rtl/branch_hazard_ctrl.sv
// Stall/redirect sequencer for ID-stage branch and JALR resolution.
// Optional perf counters are enabled by defining BRANCH_HAZARD_PERF_EN.
module branch_hazard_ctrl #(
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RF_AW-1:0] id_rs1,
  input  logic [RF_AW-1:0] id_rs2,
  input  logic             id_branch,
  input  logic             id_jalr,
  input  logic             id_jal,
  input  logic             br_taken,
  input  logic [RF_AW-1:0] id_ex_rd,
  input  logic [RF_AW-1:0] ex_mem_rd,
  input  logic             id_ex_reg_we,
  input  logic             ex_mem_reg_we,
  input  logic             id_ex_mem_re,
  input  logic             ex_mem_mem_re,
  input  logic             ext_stall,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             pc_redirect,
  output logic             hz_busy
`ifdef BRANCH_HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stall_cyc,
  output logic [31:0]      perf_redirects
`endif
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t     state, state_nxt;
  logic       cnt, cnt_nxt;
  logic       use_rs2, reads_reg;
  logic       ex_hit, mem_hit;
  logic [1:0] need;
  logic       redirect_cond;

  // JALR outranks a simultaneous branch flag, so rs2 is only live for a pure branch.
  assign use_rs2   = id_branch & ~id_jalr;
  assign reads_reg = id_branch | id_jalr;

  assign ex_hit  = id_ex_reg_we && (id_ex_rd != '0) &&
                   ((id_ex_rd == id_rs1) || (use_rs2 && (id_ex_rd == id_rs2)));
  assign mem_hit = ex_mem_reg_we && (ex_mem_rd != '0) &&
                   ((ex_mem_rd == id_rs1) || (use_rs2 && (ex_mem_rd == id_rs2)));

  assign redirect_cond = id_jalr ? 1'b1 : (id_branch ? br_taken : id_jal);

  always_comb begin
    need = 2'd0;
    if (reads_reg) begin
      if (ex_hit && id_ex_mem_re)                 need = 2'd2;
      else if (ex_hit || (mem_hit && ex_mem_mem_re)) need = 2'd1;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    pc_redirect  = 1'b0;
    if (!ext_stall) begin
      unique case (state)
        RUN: begin
          if (need != 2'd0) begin
            id_ex_bubble = 1'b1;
            if (need == 2'd2) begin
              state_nxt = HOLD;
              cnt_nxt   = 1'b0;
            end
          end else begin
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            pc_redirect = redirect_cond;
            if_id_flush = redirect_cond;
          end
        end
        HOLD: begin
          id_ex_bubble = 1'b1;
          if (cnt == 1'b0) state_nxt = RUN;
          else             cnt_nxt   = cnt - 1'b1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign hz_busy = (state == HOLD);

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef BRANCH_HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cyc <= '0;
      perf_redirects <= '0;
    end else begin
      if (id_ex_bubble) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (pc_redirect)  perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Scoreboard bench for branch_hazard_ctrl: a reference model pushes the expected
// output vector per cycle, which is popped and compared against the DUT mid-cycle.
module tb_branch_hazard_ctrl;
  localparam int RF_AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [RF_AW-1:0] id_rs1, id_rs2, id_ex_rd, ex_mem_rd;
  logic id_branch, id_jalr, id_jal, br_taken;
  logic id_ex_reg_we, ex_mem_reg_we, id_ex_mem_re, ex_mem_mem_re, ext_stall;
  logic pc_we, if_id_we, id_ex_bubble, if_id_flush, pc_redirect, hz_busy;
`ifdef BRANCH_HAZARD_PERF_EN
  logic [31:0] perf_stall_cyc, perf_redirects;
`endif

  branch_hazard_ctrl #(.RF_AW(RF_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_branch(id_branch), .id_jalr(id_jalr), .id_jal(id_jal), .br_taken(br_taken),
    .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd),
    .id_ex_reg_we(id_ex_reg_we), .ex_mem_reg_we(ex_mem_reg_we),
    .id_ex_mem_re(id_ex_mem_re), .ex_mem_mem_re(ex_mem_mem_re),
    .ext_stall(ext_stall),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .pc_redirect(pc_redirect), .hz_busy(hz_busy)
`ifdef BRANCH_HAZARD_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_redirects(perf_redirects)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [5:0] sb_q[$];
  bit   m_hold;
  int   bubbles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_need();
    logic rs2_live, src_ex, src_mem;
    rs2_live = id_branch && !id_jalr;
    src_ex  = id_ex_reg_we && (id_ex_rd != 0) &&
              (id_ex_rd == id_rs1 || (rs2_live && id_ex_rd == id_rs2));
    src_mem = ex_mem_reg_we && (ex_mem_rd != 0) &&
              (ex_mem_rd == id_rs1 || (rs2_live && ex_mem_rd == id_rs2));
    if (!(id_branch || id_jalr)) return 2'd0;
    if (src_ex && id_ex_mem_re)  return 2'd2;
    if (src_ex || (src_mem && ex_mem_mem_re)) return 2'd1;
    return 2'd0;
  endfunction

  // Expected vector: {pc_we, if_id_we, id_ex_bubble, if_id_flush, pc_redirect, hz_busy}
  function automatic logic [5:0] model_out();
    logic r;
    if (ext_stall)           return {5'b00000, m_hold};
    if (m_hold)              return 6'b001001;
    if (model_need() != 0)   return 6'b001000;
    r = id_jalr || (id_branch && br_taken) || (id_jal && !id_branch);
    return {3'b110, r, r, 1'b0};
  endfunction

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; id_ex_rd = '0; ex_mem_rd = '0;
    id_branch = 0; id_jalr = 0; id_jal = 0; br_taken = 0;
    id_ex_reg_we = 0; ex_mem_reg_we = 0; id_ex_mem_re = 0; ex_mem_mem_re = 0;
    ext_stall = 0;
  endtask

  task automatic rand_inputs();
    int f;
    clear_inputs();
    f = $urandom_range(0, 3);
    id_branch = (f == 1); id_jalr = (f == 2); id_jal = (f == 3);
    id_rs1 = RF_AW'($urandom_range(0, 3)); id_rs2 = RF_AW'($urandom_range(0, 3));
    id_ex_rd = RF_AW'($urandom_range(0, 3)); ex_mem_rd = RF_AW'($urandom_range(0, 3));
    id_ex_reg_we = 1'($urandom); ex_mem_reg_we = 1'($urandom);
    id_ex_mem_re = 1'($urandom); ex_mem_mem_re = 1'($urandom);
    br_taken = 1'($urandom);
    ext_stall = ($urandom_range(0, 4) == 0);
  endtask

  // Called just after a falling edge with inputs driven; returns at the next falling edge.
  task automatic step(input string tag);
    logic [5:0] got, exp;
    sb_q.push_back(model_out());
    #2;
    got = {pc_we, if_id_we, id_ex_bubble, if_id_flush, pc_redirect, hz_busy};
    exp = sb_q.pop_front();
    check(tag, 32'(got), 32'(exp));
    if (id_ex_bubble) bubbles++;
    if (!ext_stall) m_hold = !m_hold && (model_need() == 2'd2);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 0; m_hold = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; m_hold = 0; bubbles = 0;
    rand_inputs();
    repeat (3) begin
      @(negedge clk);
      rand_inputs();
      #1 check("rst_busy", 32'(hz_busy), 32'd0);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
    #1 check("rst_idle_vec", 32'({pc_we, if_id_we, id_ex_bubble, if_id_flush, pc_redirect, hz_busy}),
             32'(6'b110000));
    step("rst_idle");

    // ALU producer in EX feeding a branch: one bubble, then taken redirect.
    bubbles = 0;
    id_branch = 1; id_rs1 = 5; id_rs2 = 2; id_ex_rd = 5; id_ex_reg_we = 1; br_taken = 1;
    step("alu_stall");
    id_ex_reg_we = 0; ex_mem_rd = 5; ex_mem_reg_we = 1;
    step("alu_redirect");
    check("alu_bubbles", 32'(bubbles), 32'd1);
    clear_inputs();

    // Load in EX feeding JALR: two bubbles, busy only on the second.
    bubbles = 0;
    id_jalr = 1; id_rs1 = 7; id_ex_rd = 7; id_ex_reg_we = 1; id_ex_mem_re = 1;
    step("ld_stall1");
    id_ex_reg_we = 0; id_ex_mem_re = 0; ex_mem_rd = 7; ex_mem_reg_we = 1; ex_mem_mem_re = 1;
    step("ld_hold");
    ex_mem_reg_we = 0; ex_mem_mem_re = 0;
    step("ld_redirect");
    check("ld_bubbles", 32'(bubbles), 32'd2);
    clear_inputs();

    // Negative cases: x0 producer, rs2 on JALR; also not-taken branch and JAL.
    id_branch = 1; id_rs1 = 0; id_ex_rd = 0; id_ex_reg_we = 1;
    step("x0_nostall");
    clear_inputs();
    id_jalr = 1; id_rs1 = 3; id_rs2 = 9; id_ex_rd = 9; id_ex_reg_we = 1; id_ex_mem_re = 1;
    step("jalr_rs2_nostall");
    clear_inputs();
    id_jal = 1; id_ex_rd = 4; id_ex_reg_we = 1; id_ex_mem_re = 1; id_rs1 = 4;
    step("jal_noread");
    clear_inputs();

    // Branch rs2 against a load in MEM: one bubble, then not-taken fall-through.
    bubbles = 0;
    id_branch = 1; id_rs1 = 1; id_rs2 = 6; ex_mem_rd = 6; ex_mem_reg_we = 1; ex_mem_mem_re = 1;
    step("mem_ld_stall");
    ex_mem_reg_we = 0; ex_mem_mem_re = 0;
    step("mem_ld_go");
    check("mem_ld_bubbles", 32'(bubbles), 32'd1);
    clear_inputs();

    // ext_stall arriving on the HOLD cycle freezes HOLD; total bubbles stay at 2.
    bubbles = 0;
    id_branch = 1; id_rs2 = 8; id_ex_rd = 8; id_ex_reg_we = 1; id_ex_mem_re = 1; br_taken = 1;
    step("xs_stall1");
    id_ex_reg_we = 0; id_ex_mem_re = 0; ext_stall = 1;
    repeat (3) step("xs_freeze");
    ext_stall = 0;
    step("xs_hold");
    step("xs_redirect");
    check("xs_bubbles", 32'(bubbles), 32'd2);
    clear_inputs();

    // Reset asserted in HOLD abandons the stall at once.
    id_jalr = 1; id_rs1 = 3; id_ex_rd = 3; id_ex_reg_we = 1; id_ex_mem_re = 1;
    step("rh_stall1");
    #1 check("rh_in_hold", 32'(hz_busy), 32'd1);
    rst_n = 0; m_hold = 0;
    #1 check("rh_async_clear", 32'(hz_busy), 32'd0);
    @(negedge clk);
    rst_n = 1;
    clear_inputs();
    id_jal = 1;
    step("rh_after");

    // Constrained-random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      rand_inputs();
      step("rand");
    end
    clear_inputs();

`ifdef BRANCH_HAZARD_PERF_EN
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      id_branch = 1; id_rs1 = 10; id_ex_rd = 10; id_ex_reg_we = 1; br_taken = 1;
      ex_mem_reg_we = 0;
      step("perf_stall");
      id_ex_reg_we = 0; ex_mem_rd = 10; ex_mem_reg_we = 1;
      step("perf_redirect");
    end
    check("perf_stall_cyc", perf_stall_cyc, 32'd4);
    check("perf_redirects", perf_redirects, 32'd4);
    clear_inputs();
    id_branch = 1; id_rs1 = 2; id_ex_rd = 2; id_ex_reg_we = 1;
    step("perf_more");
    rst_n = 0; m_hold = 0;
    #1;
    check("perf_stall_rst", perf_stall_cyc, 32'd0);
    check("perf_redir_rst", perf_redirects, 32'd0);
    @(negedge clk);
    rst_n = 1;
    clear_inputs();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
